cdc_event_arbiter: RTL and testbench

CDC_EVENT_ARBITER -- requirements
Module: cdc_event_arbiter

---
 rtl/cdc_event_pkg.sv | 22 ++
 rtl/cdc_event_rr_picker.sv | 31 +++
 rtl/cdc_event_arbiter.sv | 115 +++++++++++
 tb/tb_cdc_event_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_event_pkg.sv
// Shared definitions for the event-to-toggle CDC arbiter: FSM encoding and width helpers.
package cdc_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // An index needs at least one bit even for a single-source corner.
  function automatic int id_width(input int num);
    return (clog2(num) < 1) ? 1 : clog2(num);
  endfunction

endpackage

// File: rtl/cdc_event_rr_picker.sv
// Round-robin winner search over the pending vector, starting just above the last grant.
module cdc_event_rr_picker #(
  parameter int NUM_EVENTS = 4,
  parameter int ID_W       = 2
) (
  input  logic [NUM_EVENTS-1:0] req,
  input  logic [ID_W-1:0]       last_grant,
  output logic                  valid,
  output logic [ID_W-1:0]       index
);

  int              cand;
  logic [ID_W-1:0] cidx;

  // Walk last_grant+1 .. last_grant+NUM_EVENTS (mod NUM_EVENTS); first set bit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    cidx  = '0;
    for (int i = 1; i <= NUM_EVENTS; i++) begin
      cand = (int'(last_grant) + i) % NUM_EVENTS;
      cidx = ID_W'(cand);
      if (!valid && req[cidx]) begin
        valid = 1'b1;
        index = cidx;
      end
    end
  end

endmodule

// File: rtl/cdc_event_arbiter.sv
// Captures rising edges on event lines, arbitrates them round-robin and ships one id at a
// time across a toggle req/ack handshake to another clock domain.
//
//   state       | meaning
//   ST_IDLE     | waiting for a pending event; winner id latched on exit
//   ST_SEND     | id stable for one cycle; req toggles and pending bit clears on exit
//   ST_WAIT_ACK | waiting for synchronized ack parity to match req
module cdc_event_arbiter
  import cdc_event_pkg::*;
#(
  parameter  int NUM_EVENTS = 4,
  parameter  int SYNC_DEPTH = 2,
  localparam int ID_W       = id_width(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] i_event,
  input  logic                  i_ovf_clr,
  output logic                  o_async_req,
  output logic [ID_W-1:0]       o_async_id,
  input  logic                  i_async_ack,
  output logic [NUM_EVENTS-1:0] o_pending,
  output logic [NUM_EVENTS-1:0] o_overflow,
  output logic                  o_busy
);

  logic [NUM_EVENTS-1:0] event_q;
  logic [NUM_EVENTS-1:0] edge_vec;
  logic [NUM_EVENTS-1:0] pending;
  logic [NUM_EVENTS-1:0] overflow;
  logic [NUM_EVENTS-1:0] clear_vec;
  logic [NUM_EVENTS-1:0] ovf_set;
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [SYNC_DEPTH-1:0] ack_sync;
  logic                  ack_s;
  state_t                state;
  state_t                state_nx;
  logic [ID_W-1:0]       last_grant;
  logic                  pick_valid;
  logic [ID_W-1:0]       pick_index;

  assign edge_vec  = i_event & ~event_q;
  assign clear_vec = (state == ST_SEND) ? (NUM_EVENTS'(1) << o_async_id) : '0;
  // A new edge colliding with the SEND clear simply re-arms the bit; it is not a loss.
  assign ovf_set   = edge_vec & pending & ~clear_vec;
  assign ack_s     = ack_sync[SYNC_DEPTH-1];
  assign o_pending  = pending;
  assign o_overflow = overflow;
  assign o_busy     = (state != ST_IDLE);

  cdc_event_rr_picker #(
    .NUM_EVENTS(NUM_EVENTS),
    .ID_W      (ID_W)
  ) u_picker (
    .req       (pending),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .index     (pick_index)
  );

  // Edge-detect register; starts from 0 so a line already high after reset counts once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) event_q <= '0;
    else          event_q <= i_event;
  end

  // Multi-flop synchronizer for the asynchronous ack toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_DEPTH-2:0], i_async_ack};
  end

  // Pending and sticky overflow flags; sets always win over clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clear_vec) | edge_vec;
      overflow <= (i_ovf_clr ? '0 : overflow) | ovf_set;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (pick_valid) state_nx = ST_SEND;
      ST_SEND:     state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_s == o_async_req) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Handshake flops: id latched leaving IDLE, req toggled leaving SEND, both glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_async_req <= 1'b0;
      o_async_id  <= '0;
      last_grant  <= ID_W'(NUM_EVENTS - 1);
    end else begin
      if (state == ST_IDLE && pick_valid) o_async_id <= pick_index;
      if (state == ST_SEND) begin
        o_async_req <= ~o_async_req;
        last_grant  <= o_async_id;
      end
    end
  end

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Self-checking bench: expected ids are queued as events are driven and popped on each
// req toggle; an optional auto-responder returns the ack after a programmable delay.
module tb_cdc_event_arbiter;

  localparam int NE = 4;
  localparam int SD = 2;

  logic          clk;
  logic          reset_n;
  logic [NE-1:0] i_event;
  logic          i_ovf_clr;
  logic          o_async_req;
  logic [1:0]    o_async_id;
  logic          i_async_ack;
  logic [NE-1:0] o_pending;
  logic [NE-1:0] o_overflow;
  logic          o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  logic       auto_ack = 1'b0;
  int         ack_dly  = 2;
  int         ack_cnt  = 0;
  logic       req_seen = 1'b0;
  logic [1:0] id_prev  = '0;

  cdc_event_arbiter #(.NUM_EVENTS(NE), .SYNC_DEPTH(SD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_event    (i_event),
    .i_ovf_clr  (i_ovf_clr),
    .o_async_req(o_async_req),
    .o_async_id (o_async_id),
    .i_async_ack(i_async_ack),
    .o_pending  (o_pending),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor and destination-side ack responder.
  always @(negedge clk) begin
    if (!reset_n) begin
      req_seen    = 1'b0;
      id_prev     = '0;
      i_async_ack = 1'b0;
      ack_cnt     = 0;
    end else begin
      if (o_async_req !== req_seen) begin
        req_seen = o_async_req;
        check("id_setup", 32'(o_async_id), 32'(id_prev));
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_send: id %0d sent, none expected", o_async_id);
        end else begin
          check("sb_id", 32'(o_async_id), exp_q.pop_front());
        end
      end
      if (auto_ack && i_async_ack !== o_async_req) begin
        if (ack_cnt >= ack_dly) begin
          i_async_ack = o_async_req;
          ack_cnt     = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
      id_prev = o_async_id;
    end
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    i_event   = '0;
    i_ovf_clr = 1'b0;
    auto_ack  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_req();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_async_req !== i_async_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!o_busy && o_pending == '0 && o_async_req === i_async_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int         n;
    logic       r_hold;
    logic [1:0] id_hold;
    int         bad;

    // Reset values
    reset_n   = 1'b0;
    i_event   = '0;
    i_ovf_clr = 1'b0;
    repeat (3) tick();
    check("rst_req", 32'(o_async_req), 32'd0);
    check("rst_id", 32'(o_async_id), 32'd0);
    check("rst_pending", 32'(o_pending), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single event on line 2
    exp_q.push_back(2);
    i_event = 4'b0100;
    tick();
    check("single_pending", 32'(o_pending), 32'h4);
    i_event = '0;
    tick();
    check("single_send_busy", 32'(o_busy), 32'd1);
    check("single_send_id", 32'(o_async_id), 32'd2);
    check("single_send_req", 32'(o_async_req), 32'd0);
    tick();
    check("single_req_toggled", 32'(o_async_req), 32'd1);
    check("single_pending_clr", 32'(o_pending), 32'd0);
    ack_dly  = 0;
    auto_ack = 1'b1;
    for (int i = 0; i < 20 && i_async_ack !== o_async_req; i++) tick();
    n = 0;
    for (int i = 0; i < 20 && o_busy; i++) begin
      tick();
      n++;
    end
    check("ack_to_idle_cycles", 32'(n), 32'(SD + 1));
    check("single_busy_low", 32'(o_busy), 32'd0);
    ack_dly = 2;

    // Round robin from last_grant=3, then from last_grant=0
    do_reset();
    auto_ack = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    i_event = 4'b1011;
    tick();
    i_event = '0;
    wait_idle();
    exp_q.push_back(0);
    i_event = 4'b0001;
    tick();
    i_event = '0;
    wait_idle();
    exp_q.push_back(1);
    exp_q.push_back(0);
    i_event = 4'b0011;
    tick();
    i_event = '0;
    wait_idle();

    // Overflow while id 0 waits for ack
    auto_ack = 1'b0;
    exp_q.push_back(0);
    i_event = 4'b0001;
    tick();
    i_event = '0;
    wait_req();
    i_event = 4'b0010;
    tick();
    i_event = '0;
    tick();
    i_event = 4'b0010;
    tick();
    i_event = '0;
    check("ovf_set", 32'(o_overflow), 32'h2);
    check("ovf_pending", 32'(o_pending), 32'h2);
    exp_q.push_back(1);
    auto_ack = 1'b1;
    wait_idle();
    check("ovf_sticky", 32'(o_overflow), 32'h2);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    check("ovf_cleared", 32'(o_overflow), 32'd0);

    // Edge on line 2 during its own SEND cycle
    auto_ack = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(2);
    i_event = 4'b0100;
    tick();
    check("sw_pending", 32'(o_pending), 32'h4);
    i_event = '0;
    tick();
    check("sw_send_id", 32'(o_async_id), 32'd2);
    i_event = 4'b0100;
    tick();
    i_event = '0;
    check("sw_pending_kept", 32'(o_pending), 32'h4);
    check("sw_no_overflow", 32'(o_overflow), 32'd0);
    auto_ack = 1'b1;
    wait_idle();

    // Reset in WAIT_ACK
    auto_ack = 1'b0;
    exp_q.push_back(1);
    i_event = 4'b0010;
    tick();
    i_event = '0;
    wait_req();
    i_event = 4'b1000;
    tick();
    i_event = '0;
    tick();
    check("mid_pending", 32'(o_pending), 32'h8);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(o_async_req), 32'd0);
    check("mid_rst_id", 32'(o_async_id), 32'd0);
    check("mid_rst_pending", 32'(o_pending), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back(0);
    i_event = 4'b0001;
    tick();
    i_event = '0;
    wait_req();
    check("post_rst_req", 32'(o_async_req), 32'd1);
    auto_ack = 1'b1;
    wait_idle();

    // Ack held for 50 cycles
    auto_ack = 1'b0;
    exp_q.push_back(3);
    i_event = 4'b1000;
    tick();
    i_event = '0;
    wait_req();
    r_hold  = o_async_req;
    id_hold = o_async_id;
    bad     = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!o_busy || o_async_req !== r_hold || o_async_id !== id_hold) bad++;
    end
    check("hold_bad_cycles", 32'(bad), 32'd0);
    check("hold_id", 32'(o_async_id), 32'd3);
    auto_ack = 1'b1;
    wait_idle();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
